// File: rtl/mult_sched.sv
// mult_sched: round-robin arbiter sharing one fixed-point multiplier between N_REQ requesters.
// Latency: request handshake in cycle T -> res_valid in T+2; sustained rate one result per 2 cycles.
// Backpressure: a result is held in HOLD until res_ready; no new grant is issued while it is held.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake; req_ready is one-hot or zero
//   req_mn1/req_mn2      packed operands, requester i at [i*N1 +: N1] / [i*N2 +: N2]
//   res_valid/res_ready  result handshake carrying res_data, res_ovr and res_id
//   ovr_cnt              saturating count of overflowed results
//   busy                 high whenever the scheduler is not idle

// mult: shared fixed-point multiplier (sign-magnitude op2, unsigned op1).
// Purely combinational; result sign is op2's sign, magnitude is a window of
// the unsigned product and ovr flags any set bit above that window.
module mult #(
  parameter int N1    = 48,
  parameter int N2    = 16,
  parameter int N_RES = 32
) (
  input  logic [N1-1:0]    op1_i,
  input  logic [N2-1:0]    op2_i,
  output logic [N_RES-1:0] res_o,
  output logic             ovr_o
);

  localparam int PW = N1 + N2;
  // Top of the magnitude window; the window is N_RES-1 bits wide.
  localparam int HI = (N_RES == 32) ? (PW - 4) : (PW - 3);
  localparam int LO = HI - N_RES + 2;

  logic [PW-1:0] prod;
  logic [LO-1:0] prod_unused;

  assign prod        = PW'(op1_i) * PW'(op2_i[N2-2:0]);
  assign res_o       = {op2_i[N2-1], prod[HI:LO]};
  assign ovr_o       = |prod[PW-1:HI+1];
  // Fraction bits below the window are truncated.
  assign prod_unused = prod[LO-1:0];

  generate
    if (N_RES != 32 && N_RES != 48) begin : g_bad_nres
      $error("mult: N_RES must be 32 or 48");
    end
  endgenerate

endmodule

module mult_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int N1    = 48,
  parameter int N2    = 16,
  parameter int N_RES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*N1-1:0]   req_mn1,
  input  logic [N_REQ*N2-1:0]   req_mn2,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [N_RES-1:0]      res_data,
  output logic                  res_ovr,
  output logic [ID_W-1:0]       res_id,
  output logic [15:0]           ovr_cnt,
  output logic                  busy
);

  generate
    if (N_RES != 32 && N_RES != 48) begin : g_chk_nres
      $error("mult_sched: N_RES must be 32 or 48");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_chk_nreq
      $error("mult_sched: N_REQ must be in 2..8");
    end
    if (ID_W != $clog2(N_REQ)) begin : g_chk_idw
      $error("mult_sched: ID_W must equal clog2(N_REQ)");
    end
  endgenerate

  // One extra bit so last_grant + k (k up to N_REQ) never wraps before the modulo fix-up.
  localparam int CW = ID_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [N1-1:0]   op1;
    logic [N2-1:0]   op2;
    logic [ID_W-1:0] id;
  } op_t;

  typedef struct packed {
    logic [N_RES-1:0] data;
    logic             ovr;
    logic [ID_W-1:0]  id;
  } res_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  op_t             op_q, op_d;
  res_t            res_q, res_d;
  logic [15:0]     ovr_cnt_q, ovr_cnt_d;

  logic            opp;
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [CW-1:0]   cand;
  logic            hs;
  logic [N_RES-1:0] mult_res;
  logic            mult_ovr;

  // A grant can only be issued when the output stage is free or being drained this cycle.
  assign opp = (state_q == S_IDLE) || ((state_q == S_HOLD) && res_ready);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_grant_q} + CW'(k);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (opp && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign hs = |(req_valid & req_ready);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (hs) state_d = S_MUL;
      end
      S_MUL: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) state_d = hs ? S_MUL : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand capture: only at the handshake edge, so requesters may change
  // their operands freely after being accepted.
  always_comb begin
    op_d         = op_q;
    last_grant_d = last_grant_q;
    if (hs) begin
      op_d.op1     = req_mn1[int'(gnt_idx)*N1 +: N1];
      op_d.op2     = req_mn2[int'(gnt_idx)*N2 +: N2];
      op_d.id      = gnt_idx;
      last_grant_d = gnt_idx;
    end
  end

  mult #(
    .N1    (N1),
    .N2    (N2),
    .N_RES (N_RES)
  ) u_mult (
    .op1_i (op_q.op1),
    .op2_i (op_q.op2),
    .res_o (mult_res),
    .ovr_o (mult_ovr)
  );

  // Result and overflow counter update at the end of the MUL cycle.
  always_comb begin
    res_d     = res_q;
    ovr_cnt_d = ovr_cnt_q;
    if (state_q == S_MUL) begin
      res_d.data = mult_res;
      res_d.ovr  = mult_ovr;
      res_d.id   = op_q.id;
      if (mult_ovr && (ovr_cnt_q != 16'hFFFF)) begin
        ovr_cnt_d = ovr_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      op_q         <= '0;
      res_q        <= '0;
      ovr_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      res_q        <= res_d;
      ovr_cnt_q    <= ovr_cnt_d;
    end
  end

  assign res_valid = (state_q == S_HOLD);
  assign res_data  = res_q.data;
  assign res_ovr   = res_q.ovr;
  assign res_id    = res_q.id;
  assign ovr_cnt   = ovr_cnt_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: randomized and directed stimulus for mult_sched with a queue scoreboard.
// Grants and phase are predicted from round-robin rules; results are predicted with plain arithmetic.
// A separate monitor compares every presented result against the queue head.
module tb_mult_sched;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int N1    = 48;
  localparam int N2    = 16;
  localparam int N_RES = 32;

  localparam int P_IDLE = 0;
  localparam int P_MUL  = 1;
  localparam int P_HOLD = 2;

  typedef struct {
    logic [N_RES-1:0] data;
    logic             ovr;
    logic [ID_W-1:0]  id;
    logic [15:0]      cnt;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*N1-1:0] req_mn1;
  logic [N_REQ*N2-1:0] req_mn2;
  logic                res_valid;
  logic                res_ready = 1'b1;
  logic [N_RES-1:0]    res_data;
  logic                res_ovr;
  logic [ID_W-1:0]     res_id;
  logic [15:0]         ovr_cnt;
  logic                busy;

  logic [N1-1:0] mn1 [N_REQ];
  logic [N2-1:0] mn2 [N_REQ];

  int total = 0;
  int bad   = 0;

  int   serve_cnt [N_REQ];   // written by the observer
  int   seen_cnt  [N_REQ];   // written by the stimulus process
  logic do_preset = 1'b0;
  bit   forced = 1'b0;

  int          ph;
  int          mlast;
  logic [15:0] mcnt;
  exp_t        q [$];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_pack
      assign req_mn1[gi*N1 +: N1] = mn1[gi];
      assign req_mn2[gi*N2 +: N2] = mn2[gi];
    end
  endgenerate

  mult_sched #(
    .N_REQ (N_REQ), .ID_W (ID_W), .N1 (N1), .N2 (N2), .N_RES (N_RES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mn1   (req_mn1),
    .req_mn2   (req_mn2),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovr   (res_ovr),
    .res_id    (res_id),
    .ovr_cnt   (ovr_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Observer: predicts grants and the visible phase, and queues expected results.
  always @(negedge clk) begin : obs
    logic             opp;
    int               pred;
    logic [N_REQ-1:0] exp_rdy;
    logic [63:0]      prod;
    exp_t             e;
    if (!rst_n) begin
      chk("rst req_ready", req_ready, 0);
      chk("rst res_valid", res_valid, 0);
      chk("rst res_data", res_data, 0);
      chk("rst res_ovr", res_ovr, 0);
      chk("rst res_id", res_id, 0);
      chk("rst ovr_cnt", ovr_cnt, 0);
      chk("rst busy", busy, 0);
      ph    = P_IDLE;
      mlast = N_REQ - 1;
      mcnt  = 16'd0;
      q.delete();
    end else begin
      opp  = (ph == P_IDLE) || (ph == P_HOLD && res_ready);
      pred = -1;
      for (int k = 1; k <= N_REQ; k++) begin
        if (pred < 0 && req_valid[(mlast + k) % N_REQ]) pred = (mlast + k) % N_REQ;
      end
      exp_rdy = '0;
      if (opp && pred >= 0) exp_rdy[pred] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, ph != P_IDLE);
      chk("res_valid", res_valid, ph == P_HOLD);
      if (opp && pred >= 0) begin
        prod   = {16'd0, mn1[pred]} * {49'd0, mn2[pred][N2-2:0]};
        e.data = {mn2[pred][N2-1], 31'((prod >> 30) & 64'h7FFF_FFFF)};
        e.ovr  = (prod >= 64'h2000_0000_0000_0000);
        e.id   = ID_W'(pred);
        if (e.ovr && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
        e.cnt  = mcnt;
        q.push_back(e);
        mlast  = pred;
        serve_cnt[pred]++;
        ph     = P_MUL;
      end else if (ph == P_MUL) begin
        ph = P_HOLD;
      end else if (ph == P_HOLD && res_ready) begin
        ph = P_IDLE;
      end
      // Preload the overflow counter close to saturation (only while idle).
      if (forced) begin
        release dut.ovr_cnt_q;
        forced = 1'b0;
      end else if (do_preset) begin
        force dut.ovr_cnt_q = 16'hFFFE;
        mcnt   = 16'hFFFE;
        forced = 1'b1;
      end
    end
  end

  // Monitor: every cycle a result is presented it must match the queue head.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      chk("result pending", q.size() != 0, 1'b1);
      if (q.size() != 0) begin
        chk("res_data", res_data, q[0].data);
        chk("res_ovr", res_ovr, q[0].ovr);
        chk("res_id", res_id, q[0].id);
        chk("ovr_cnt", ovr_cnt, q[0].cnt);
        if (res_ready) void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_serve(input int i);
    int n;
    n = 0;
    while (serve_cnt[i] == seen_cnt[i] && n < 100) begin
      tick();
      n++;
    end
    chk("grant wait", serve_cnt[i] != seen_cnt[i], 1'b1);
    seen_cnt[i] = serve_cnt[i];
  endtask

  task automatic send(input int i, input logic [N1-1:0] a, input logic [N2-1:0] b);
    mn1[i]       = a;
    mn2[i]       = b;
    seen_cnt[i]  = serve_cnt[i];
    req_valid[i] = 1'b1;
    wait_serve(i);
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n         = 0;
    req_valid = '0;
    res_ready = 1'b1;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    tick();
    chk("drain idle", busy, 1'b0);
    for (int i = 0; i < N_REQ; i++) seen_cnt[i] = serve_cnt[i];
  endtask

  task automatic rand_op(input int i);
    logic [N1-1:0] a;
    a      = N1'({$urandom, $urandom});
    a      = a >> $urandom_range(40);
    mn1[i] = a;
    mn2[i] = N2'($urandom);
  endtask

  task automatic run_rand(input int ncyc, input int pv, input int pd, input int pr);
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (serve_cnt[i] != seen_cnt[i]) begin
          seen_cnt[i]  = serve_cnt[i];
          req_valid[i] = ($urandom_range(99) < pv);
          rand_op(i);
        end else if (req_valid[i]) begin
          if ($urandom_range(99) < pd) req_valid[i] = 1'b0;
          else if ($urandom_range(3) == 0) rand_op(i);
        end else begin
          req_valid[i] = ($urandom_range(99) < pv);
          rand_op(i);
        end
      end
      res_ready = ($urandom_range(99) < pr);
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      mn1[i]       = '0;
      mn2[i]       = '0;
      seen_cnt[i]  = 0;
      serve_cnt[i] = 0;
    end
    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Basic and sign cases.
    send(0, 48'h0000_4000_0000, 16'h0001);
    drain();
    send(2, 48'h0000_4000_0000, 16'h8001);
    drain();

    // Overflow, then saturation from a preloaded count.
    send(1, 48'hFFFF_FFFF_FFFF, 16'h7FFF);
    drain();
    do_preset = 1'b1;
    tick();
    do_preset = 1'b0;
    repeat (2) tick();
    repeat (3) send(3, 48'hFFFF_FFFF_FFFF, 16'h7FFF);
    drain();

    // Backpressure: hold a result, queue requester 1, then release.
    res_ready = 1'b0;
    send(0, 48'h0000_1234_5678, 16'h0ABC);
    mn1[1]       = 48'h0000_8000_0000;
    mn2[1]       = 16'h8003;
    req_valid[1] = 1'b1;
    repeat (6) tick();
    res_ready = 1'b1;
    wait_serve(1);
    req_valid[1] = 1'b0;
    drain();

    // Reset while an operation is in the multiplier.
    send(3, 48'h0000_0000_FFFF, 16'h0101);
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk("async rst res_valid", res_valid, 1'b0);
    chk("async rst busy", busy, 1'b0);
    chk("async rst ovr_cnt", ovr_cnt, 16'h0000);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < N_REQ; i++) seen_cnt[i] = serve_cnt[i];

    // All requesters busy with res_ready high: strict rotation from requester 0.
    run_rand(24, 100, 0, 100);
    drain();

    // Random traffic with drops, operand churn and backpressure.
    run_rand(3000, 50, 15, 70);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_sched.md
Name: mult_sched

Overview:
- Round-robin scheduler that shares one fixed-point multiplier (`mult`) between N_REQ requesters.
- Each requester presents a 48-bit × 16-bit operand pair with a valid/ready handshake.
- The block serialises operations through the single multiplier and returns each result, its overflow flag and the requester ID on one valid/ready output channel.
- It also keeps a saturating overflow counter. It sits between the filter/control front-ends and the shared FP multiplier.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester ID; must equal ceil(log2(N_REQ))
- N1, 48, width of operand 1
- N2, 16, width of operand 2; MSB is the sign bit
- N_RES, 32, result width; only 32 or 48 are legal, any other value fails elaboration via a generate-time check

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester grant/accept, at most one bit high (one-hot or zero)
- req_mn1  in  N_REQ*N1  packed operand 1; requester i at [i*N1 +: N1]
- req_mn2  in  N_REQ*N2  packed operand 2; requester i at [i*N2 +: N2]
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- res_data  out  N_RES  multiplier result
- res_ovr  out  1  multiplier overflow flag for res_data
- res_id  out  ID_W  index of the requester that owns res_data
- ovr_cnt  out  16  saturating count of overflowed results
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert by system):
  - Outputs: req_ready=0, res_valid=0, res_data=0, res_ovr=0, res_id=0, ovr_cnt=0, busy=0.
  - Internal: state=IDLE, last_grant=N_REQ-1, so the first grant goes to requester 0.
- FSM states: IDLE, MUL, HOLD.
- Grant opportunity exists in IDLE, or in HOLD when res_ready=1.
- Arbitration during a grant opportunity:
  - Search req_valid round-robin starting at last_grant+1, wrapping at N_REQ.
  - The first valid index g gets req_ready[g]=1 combinationally in that cycle. All other req_ready bits are 0.
  - req_ready is 0 outside grant opportunities, even if req_valid is high.
  - Handshake = req_valid[g] & req_ready[g]. On it, the clock edge latches op1/op2/id registers from requester g, sets last_grant=g, and moves to MUL.
- IDLE:
  - No valid request: stay in IDLE.
  - Otherwise: grant and go to MUL.
- MUL:
  - The shared mult sees only the op registers.
  - At the end of the cycle, capture mult result/ovr into res_data/res_ovr, op id into res_id, set res_valid=1, go to HOLD.
  - If ovr=1 and ovr_cnt<16'hFFFF, increment ovr_cnt; it holds at 16'hFFFF.
- HOLD:
  - res_valid=1; res_data/res_ovr/res_id stay stable until accepted.
  - res_ready=0: stay in HOLD; no grants.
  - res_ready=1 and a request is valid: grant in the same cycle, go to MUL; res_valid drops next cycle.
  - res_ready=1 and no request: go to IDLE; res_valid=0 next cycle.
- Latency and throughput:
  - Request handshake at cycle T gives res_valid=1 at T+2.
  - Sustained throughput is one result per 2 cycles when res_ready is held high.
- Multiplier function (fixed by `mult`):
  - Sign bit: res_data[N_RES-1] = op2[N2-1].
  - Magnitude: op1 × op2[N2-2:0] as an unsigned (N1+N2)-bit product.
  - N_RES=32: magnitude = product[N1+N2-4:30]; ovr = |product[N1+N2-1:N1+N2-3].
  - N_RES=48: magnitude = product[N1+N2-3:15]; ovr = |product[N1+N2-1:N1+N2-2].
- Boundary conditions:
  - A requester that drops req_valid before being granted is simply skipped; no state is kept for it.
  - Operands are sampled only at the handshake edge.
  - A single requester valid every cycle is granted every opportunity; wrap-around search returns to it.
  - Reset asserted mid-operation discards the in-flight op and any held result; no res_valid pulse is produced afterwards.

Test Plan:
1. Basic, N_RES=32: req 0 sends mn1=48'h0000_4000_0000, mn2=16'h0001 → res_valid at T+2 with res_data=32'h0000_0001, res_ovr=0, res_id=0, ovr_cnt=0.
2. Sign: req 2 sends mn1=48'h0000_4000_0000, mn2=16'h8001 → res_data=32'h8000_0001, res_id=2.
3. Overflow and saturation:
   - mn1=48'hFFFF_FFFF_FFFF, mn2=16'h7FFF → res_ovr=1, ovr_cnt=1.
   - Force ovr_cnt to 16'hFFFE, then send 3 overflowing ops → ovr_cnt stays at 16'hFFFF.
4. Round-robin: all 4 req_valid held high, res_ready=1 → grants 0,1,2,3,0 on consecutive opportunities every 2 cycles; res_id sequence 0,1,2,3,0.
5. Backpressure: res_ready=0 for 5 cycles in HOLD → res_data/res_id stable, all req_ready=0. Raise res_ready with req 1 valid → req_ready[1]=1 in that cycle, next result at +2.
6. Reset mid-op: assert rst_n=0 while in MUL → immediately res_valid=0, busy=0, ovr_cnt=0. After release, first grant goes to req 0.
